data_memory_stage: RTL and testbench

Memory-access stage of the multicycle ARM datapath, between execute and writeback. Performs ARM single-data-transfer (LDR/STR, word or byte) against an internal synchronous word-addressed data RAM. Computes the effective address from base and offset, performs the access, and returns load data plus the updated base for writeback. Uses a start/done handshake driven by the control FSM.

---
 rtl/data_memory_stage.sv | 148 ++++++++++++++
 tb/tb_data_memory_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_stage.sv
// Memory-access stage for LDR/STR (word/byte) against an internal word-addressed RAM.
// Latency: done 2 cycles after an accepted start for loads and word stores, 3 for byte stores.
// Backpressure: none; start is accepted only in IDLE, and start while busy is dropped.
//
// Ports:
//   clk, nreset (async, active-high)  clock and reset
//   start                             request, sampled only while idle
//   load_store/byte_or_word/pre_post/up_down/write_back   ARM L/B/P/U/W bits
//   base, offset, store_data          Rn, decoded offset, Rd for stores
//   busy, done                        status and one-cycle completion pulse
//   load_data                         load result (zero outside a load's done cycle)
//   wb_addr, wb_base_en               effective address and base writeback request
module data_memory_stage #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic        load_store,
  input  logic        byte_or_word,
  input  logic        pre_post,
  input  logic        up_down,
  input  logic        write_back,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [31:0] wb_addr,
  output logic        wb_base_en
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, MODIFY, FINISH} stateT;

  stateT                 state;
  stateT                 stateNext;
  logic [31:0]           ram [DEPTH];

  logic                  isLoad;
  logic                  isByte;
  logic                  isPre;
  logic                  isWb;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [1:0]            lane;
  logic [31:0]           eaQ;
  logic [31:0]           storeQ;
  logic [31:0]           memQ;

  logic [31:0]           ea;
  logic [31:0]           accAddr;
  logic                  unusedAddrBits;
  logic                  ramWe;
  logic [31:0]           ramWdata;
  logic [4:0]            laneShift;
  logic [31:0]           laneMask;
  logic [7:0]            loadByte;

  // Effective address wraps mod 2^32; the RAM only sees the word index, so
  // address bits above the RAM depth simply alias.
  assign ea             = up_down ? (base + offset) : (base - offset);
  assign accAddr        = pre_post ? ea : base;
  assign unusedAddrBits = ^accAddr[31:ADDR_WIDTH+2];

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = ACCESS;
      // Byte stores need the old word first so the other lanes survive.
      ACCESS:  stateNext = (!isLoad && isByte) ? MODIFY : FINISH;
      MODIFY:  stateNext = FINISH;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      isLoad  <= 1'b0;
      isByte  <= 1'b0;
      isPre   <= 1'b0;
      isWb    <= 1'b0;
      wordIdx <= '0;
      lane    <= 2'd0;
      eaQ     <= 32'd0;
      storeQ  <= 32'd0;
      memQ    <= 32'd0;
    end else begin
      if (state == IDLE && start) begin
        isLoad  <= load_store;
        isByte  <= byte_or_word;
        isPre   <= pre_post;
        isWb    <= write_back;
        wordIdx <= accAddr[ADDR_WIDTH+1:2];
        lane    <= accAddr[1:0];
        eaQ     <= ea;
        storeQ  <= store_data;
      end
      if (state == ACCESS && (isLoad || isByte)) begin
        memQ <= ram[wordIdx];
      end
    end
  end

  // Write enable is decoded from the current state, so an asynchronous reset
  // that lands in MODIFY drops the state to IDLE and suppresses the write.
  assign laneShift = {lane, 3'b000};
  assign laneMask  = 32'h0000_00FF << laneShift;
  assign ramWe     = (state == ACCESS && !isLoad && !isByte) || (state == MODIFY);
  assign ramWdata  = (state == MODIFY)
                   ? ((memQ & ~laneMask) | ({24'd0, storeQ[7:0]} << laneShift))
                   : storeQ;

  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram[wordIdx] <= ramWdata;
    end
  end

  always_comb begin
    loadByte = memQ[7:0];
    case (lane)
      2'd0: loadByte = memQ[7:0];
      2'd1: loadByte = memQ[15:8];
      2'd2: loadByte = memQ[23:16];
      2'd3: loadByte = memQ[31:24];
      default: loadByte = memQ[7:0];
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
  assign load_data  = (done && isLoad) ? (isByte ? {24'd0, loadByte} : memQ) : 32'd0;
  assign wb_addr    = eaQ;
  // Post-indexed transfers always update the base.
  assign wb_base_en = done && (isWb || !isPre);

endmodule

// File: tb/tb_data_memory_stage.sv
// Randomized bench for data_memory_stage with a flat-array memory model.
// Each operation is driven through a start pulse and checked at its done pulse.
// Inputs are scrambled after acceptance so un-latched paths are exposed.
module tb_data_memory_stage;

  logic        clk;
  logic        nreset;
  logic        start;
  logic        load_store;
  logic        byte_or_word;
  logic        pre_post;
  logic        up_down;
  logic        write_back;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [31:0] wb_addr;
  logic        wb_base_en;

  logic [31:0] refMem [256];
  int          nCompared;
  int          nMismatched;

  data_memory_stage #(.ADDR_WIDTH(8)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .start       (start),
    .load_store  (load_store),
    .byte_or_word(byte_or_word),
    .pre_post    (pre_post),
    .up_down     (up_down),
    .write_back  (write_back),
    .base        (base),
    .offset      (offset),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .load_data   (load_data),
    .wb_addr     (wb_addr),
    .wb_base_en  (wb_base_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int wordOf(input logic [31:0] addr);
    return int'((addr / 4) % 256);
  endfunction

  task automatic scramble();
    base       = $urandom;
    offset     = $urandom;
    store_data = $urandom;
    load_store = 1'($urandom);
    pre_post   = 1'($urandom);
  endtask

  // One full transfer. poke raises start on every busy cycle; it must be ignored.
  task automatic runOp(input bit l, input bit b, input bit p, input bit u, input bit w,
                       input logic [31:0] bs, input logic [31:0] off, input logic [31:0] sd,
                       input bit poke);
    logic [31:0] ea;
    logic [31:0] addr;
    logic [31:0] expLoad;
    int          idx;
    int          ln;
    int          cyc;
    int          expCyc;
    bit          gotDone;
    ea      = u ? bs + off : bs - off;
    addr    = p ? ea : bs;
    idx     = wordOf(addr);
    ln      = int'(addr % 4);
    expCyc  = (!l && b) ? 2 : 1;
    expLoad = 32'd0;
    if (l) expLoad = b ? ((refMem[idx] >> (8 * ln)) & 32'hFF) : refMem[idx];

    @(negedge clk);
    load_store = l; byte_or_word = b; pre_post = p; up_down = u; write_back = w;
    base = bs; offset = off; store_data = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    check("busy_after_start", {30'd0, busy, done}, 32'h2);
    check("load_data_idle", load_data, 32'd0);

    if (!l) begin
      if (b) refMem[idx][8*ln +: 8] = sd[7:0];
      else   refMem[idx] = sd;
    end

    cyc = 0;
    gotDone = 1'b0;
    while (!gotDone && cyc < 8) begin
      if (poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      gotDone = done;
    end
    check("done_latency", 32'(cyc), 32'(expCyc));
    if (l) check("load_data", load_data, expLoad);
    check("wb_addr", wb_addr, ea);
    check("wb_base_en", 32'(wb_base_en), 32'(w || !p));
    @(posedge clk); #1;
    check("single_done", {30'd0, busy, done}, 32'd0);
    check("wb_en_after", 32'(wb_base_en), 32'd0);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    nreset = 1'b1; start = 1'b0;
    load_store = 1'b0; byte_or_word = 1'b0; pre_post = 1'b0; up_down = 1'b0; write_back = 1'b0;
    base = 32'd0; offset = 32'd0; store_data = 32'd0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wb_en", 32'(wb_base_en), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_wb_addr", wb_addr, 32'd0);
    @(negedge clk);
    nreset = 1'b0;

    // Give every RAM word a known value.
    for (int i = 0; i < 256; i++) runOp(0, 0, 1, 1, 0, 32'(i * 4), 32'd0, $urandom, 0);

    // Word store then load.
    runOp(0, 0, 1, 1, 0, 32'h10, 32'd4, 32'hDEADBEEF, 0);
    runOp(1, 0, 1, 1, 0, 32'h10, 32'd4, 32'd0, 0);

    // Byte store lane merge, then word and byte loads.
    runOp(0, 0, 1, 1, 0, 32'h20, 32'd0, 32'h11223344, 0);
    runOp(0, 1, 1, 1, 0, 32'h22, 32'd0, 32'hFFFFFFAB, 0);
    runOp(1, 0, 1, 1, 0, 32'h20, 32'd0, 32'd0, 0);
    runOp(1, 1, 1, 1, 0, 32'h22, 32'd0, 32'd0, 0);

    // Post-indexed down: access at base, base written back even with W=0.
    runOp(1, 0, 0, 0, 0, 32'h40, 32'd8, 32'd0, 0);

    // Address wrap and effective-address underflow.
    runOp(0, 0, 1, 1, 0, 32'h400, 32'd0, 32'h5, 0);
    runOp(1, 0, 1, 1, 0, 32'h0, 32'd0, 32'd0, 0);
    runOp(1, 0, 0, 0, 0, 32'h0, 32'd4, 32'd0, 0);
    runOp(1, 1, 1, 0, 1, 32'h0, 32'd1, 32'd0, 0);

    // Start held during busy cycles.
    runOp(0, 0, 1, 1, 0, 32'h80, 32'd0, 32'hCAFEF00D, 1);
    runOp(0, 1, 1, 1, 1, 32'h81, 32'd0, 32'h0000005A, 1);
    runOp(1, 0, 1, 1, 0, 32'h80, 32'd0, 32'd0, 1);

    // Reset landing in MODIFY: no write, no done.
    @(negedge clk);
    load_store = 1'b0; byte_or_word = 1'b1; pre_post = 1'b1; up_down = 1'b1; write_back = 1'b1;
    base = 32'h101; offset = 32'd0; store_data = 32'h000000EE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("modify_busy", {30'd0, busy, done}, 32'h2);
    nreset = 1'b1;
    #1;
    check("rstmod_busy", 32'(busy), 32'd0);
    check("rstmod_done", 32'(done), 32'd0);
    check("rstmod_wb_addr", wb_addr, 32'd0);
    @(negedge clk);
    nreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstmod_no_done", 32'(done), 32'd0);
    end
    runOp(1, 0, 1, 1, 0, 32'h100, 32'd0, 32'd0, 0);

    // Reset in FINISH kills done at once; the earlier store persists.
    @(negedge clk);
    load_store = 1'b0; byte_or_word = 1'b0; pre_post = 1'b1; up_down = 1'b1; write_back = 1'b1;
    base = 32'h200; offset = 32'd8; store_data = 32'h600DD00D; start = 1'b1;
    refMem[wordOf(32'h208)] = 32'h600DD00D;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("finish_done", {30'd0, busy, done}, 32'h3);
    nreset = 1'b1;
    #1;
    check("rstfin_done", 32'(done), 32'd0);
    check("rstfin_wb_en", 32'(wb_base_en), 32'd0);
    @(negedge clk);
    nreset = 1'b0;
    runOp(1, 0, 1, 1, 0, 32'h208, 32'd0, 32'd0, 0);

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      runOp(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom_range(0, 64), $urandom, ($urandom % 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
